// File: rtl/oob_link_supervisor_if.sv
// Signal bundle between the per-lane OOB link supervisor and the PHY/AHCI side.
// master = supervisor, slave = sequencer/host side that drives the lane inputs.
interface oob_link_supervisor_if #(
    parameter int NUM_LANES = 2,
    parameter int ERR_W     = 8
);
    logic [NUM_LANES-1:0]       gtx_ready;
    logic [NUM_LANES-1:0]       oob_busy;
    logic [NUM_LANES-1:0]       link_up;
    logic [NUM_LANES-1:0]       link_down;
    logic [NUM_LANES-1:0]       oob_error;
    logic [NUM_LANES-1:0]       oob_silence;
    logic [NUM_LANES-1:0]       cominit_req;
    logic [NUM_LANES-1:0]       rxbyteisaligned;
    logic [NUM_LANES-1:0]       set_offline;
    logic [NUM_LANES-1:0]       comreset_send;
    logic [NUM_LANES-1:0]       oob_start;
    logic [NUM_LANES-1:0]       phy_ready;
    logic [NUM_LANES-1:0]       re_aligned;
    logic [NUM_LANES-1:0]       txelecidle_force;
    logic [NUM_LANES-1:0]       link_fail;
    logic [4*NUM_LANES-1:0]     retry_cnt;
    logic [ERR_W*NUM_LANES-1:0] err_cnt;

    modport master (
        input  gtx_ready, oob_busy, link_up, link_down, oob_error, oob_silence,
               cominit_req, rxbyteisaligned, set_offline, comreset_send,
        output oob_start, phy_ready, re_aligned, txelecidle_force, link_fail,
               retry_cnt, err_cnt
    );

    modport slave (
        output gtx_ready, oob_busy, link_up, link_down, oob_error, oob_silence,
               cominit_req, rxbyteisaligned, set_offline, comreset_send,
        input  oob_start, phy_ready, re_aligned, txelecidle_force, link_fail,
               retry_cnt, err_cnt
    );
endinterface

// File: rtl/oob_link_supervisor.sv
// Per-lane SATA OOB supervisor: start/retry with exponential backoff, sticky
// failure, alignment-tolerant phy_ready, AHCI offline/COMRESET, error counting.
module oob_link_supervisor #(
    parameter int NUM_LANES    = 2,
    parameter int BACKOFF_BASE = 16,
    parameter int BACKOFF_W    = 12,
    parameter int MAX_RETRIES  = 3,
    parameter int ERR_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    oob_link_supervisor_if.master bus
);

    typedef enum logic [2:0] {
        WAIT_GTX, START, BUSY, LINK, BACKOFF, OFFLINE, FAIL
    } lane_state_e;

    localparam int                   WIDE_W      = BACKOFF_W + 48;
    localparam logic [4:0]           RETRY_LIMIT = 5'(MAX_RETRIES);
    localparam logic [BACKOFF_W-1:0] TIMER_ONE   = {{(BACKOFF_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]     ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

    // BACKOFF_BASE << shift, clamped to the timer's all-ones value.
    function automatic logic [BACKOFF_W-1:0] backoff_load(input logic [3:0] shift);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(BACKOFF_BASE) << shift;
        if (|wide[WIDE_W-1:BACKOFF_W]) backoff_load = '1;
        else                           backoff_load = wide[BACKOFF_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_state_e          state_q, state_d;
        logic [BACKOFF_W-1:0] timer_q, timer_d;
        logic [3:0]           retry_q, retry_d;
        logic [ERR_W-1:0]     err_q, err_d;
        logic                 ready_q, ready_d, realign_q, rx_d1_q;
        logic                 err_evt, start_o, idle_o, fail_o;
        logic                 gtx, busy, up, down, err_in, sil, cominit, rx, offline, comreset;

        assign gtx      = bus.gtx_ready[i];
        assign busy     = bus.oob_busy[i];
        assign up       = bus.link_up[i];
        assign down     = bus.link_down[i];
        assign err_in   = bus.oob_error[i];
        assign sil      = bus.oob_silence[i];
        assign cominit  = bus.cominit_req[i];
        assign rx       = bus.rxbyteisaligned[i];
        assign offline  = bus.set_offline[i];
        assign comreset = bus.comreset_send[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= WAIT_GTX;
                timer_q   <= '0;
                retry_q   <= '0;
                err_q     <= '0;
                ready_q   <= 1'b0;
                realign_q <= 1'b0;
                rx_d1_q   <= 1'b0;
            end else begin
                // NOTE: non-blocking so every register samples pre-edge values.
                state_q   <= state_d;
                timer_q   <= timer_d;
                retry_q   <= retry_d;
                err_q     <= err_d;
                ready_q   <= ready_d;
                realign_q <= ready_q & rx & ~rx_d1_q;
                rx_d1_q   <= rx;
            end
        end

        always_comb begin
            // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
            state_d = state_q;
            timer_d = timer_q;
            retry_d = retry_q;
            err_d   = err_q;
            err_evt = ((state_q == BUSY) && !up && (err_in || sil)) ||
                      ((state_q == LINK) && down);
            if (err_evt && (err_q != '1)) err_d = err_q + ERR_ONE;

            if (comreset) begin
                state_d = WAIT_GTX;
                retry_d = '0;
                timer_d = '0;
            end else if (offline) begin
                state_d = OFFLINE;
            end else begin
                case (state_q)
                    WAIT_GTX: if (gtx && !busy) state_d = START;
                    START:    state_d = BUSY;
                    BUSY: begin
                        if (up) begin
                            state_d = LINK;
                            retry_d = '0;
                        end else if (err_in || sil) begin
                            retry_d = retry_q + 4'd1;
                            if (({1'b0, retry_q} + 5'd1) < RETRY_LIMIT) begin
                                state_d = BACKOFF;
                                timer_d = backoff_load(retry_q);
                            end else begin
                                state_d = FAIL;
                            end
                        end else if (!gtx) begin
                            state_d = WAIT_GTX;
                        end
                    end
                    LINK: begin
                        if (down || !gtx) state_d = WAIT_GTX;
                        else if (cominit) state_d = START;
                    end
                    BACKOFF: begin
                        timer_d = timer_q - TIMER_ONE;
                        if (cominit)                 state_d = START;
                        else if (timer_q == TIMER_ONE) state_d = WAIT_GTX;
                    end
                    OFFLINE, FAIL: state_d = state_q;
                    default:       state_d = WAIT_GTX;
                endcase
            end

            // Readiness latches within one LINK residency and drops as LINK is left.
            ready_d = (state_d == LINK) && (ready_q || ((state_q == LINK) && rx));
        end

        always_comb begin
            start_o = (state_q == START);
            idle_o  = (state_q == OFFLINE);
            fail_o  = (state_q == FAIL);
        end

        assign bus.oob_start[i]                = start_o;
        assign bus.txelecidle_force[i]         = idle_o;
        assign bus.link_fail[i]                = fail_o;
        assign bus.phy_ready[i]                = ready_q;
        assign bus.re_aligned[i]               = realign_q;
        assign bus.retry_cnt[4*i +: 4]         = retry_q;
        assign bus.err_cnt[ERR_W*i +: ERR_W]   = err_q;
    end

endmodule

// File: tb/tb_oob_link_supervisor.sv
// Directed scenarios plus randomized traffic, compared every cycle against a
// lane-level behavioural model of the supervisor.
module tb_oob_link_supervisor;
    localparam int NL = 2;
    localparam int BB = 16;
    localparam int BW = 12;
    localparam int MR = 3;
    localparam int EW = 8;

    // Model phases of a lane.
    localparam int M_IDLE = 0;  // waiting for transceiver
    localparam int M_REQ  = 1;  // start request cycle
    localparam int M_NEG  = 2;  // negotiating
    localparam int M_UP   = 3;  // link up
    localparam int M_HOLD = 4;  // backing off
    localparam int M_OFF  = 5;  // forced idle
    localparam int M_DEAD = 6;  // retries exhausted

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oob_link_supervisor_if #(.NUM_LANES(NL), .ERR_W(EW)) bus ();

    oob_link_supervisor #(
        .NUM_LANES(NL), .BACKOFF_BASE(BB), .BACKOFF_W(BW),
        .MAX_RETRIES(MR), .ERR_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int m_mode[NL], m_retries[NL], m_err[NL], m_hold_len[NL], m_hold_done[NL];
    bit m_ready[NL], m_realign[NL], m_rx_prev[NL];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_mode[i] = M_IDLE; m_retries[i] = 0; m_err[i] = 0;
            m_hold_len[i] = 0; m_hold_done[i] = 0;
            m_ready[i] = 0; m_realign[i] = 0; m_rx_prev[i] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < NL; i++) begin
            bit gtx, busy, up, down, oerr, sil, cinit, rx, offl, cres;
            int old, nm;
            gtx = bus.gtx_ready[i]; busy = bus.oob_busy[i]; up = bus.link_up[i];
            down = bus.link_down[i]; oerr = bus.oob_error[i]; sil = bus.oob_silence[i];
            cinit = bus.cominit_req[i]; rx = bus.rxbyteisaligned[i];
            offl = bus.set_offline[i]; cres = bus.comreset_send[i];
            old = m_mode[i];
            nm  = old;
            if ((old == M_NEG && !up && (oerr || sil)) || (old == M_UP && down))
                m_err[i] = (m_err[i] < (1 << EW) - 1) ? m_err[i] + 1 : m_err[i];
            if (cres) begin
                nm = M_IDLE; m_retries[i] = 0;
            end else if (offl) begin
                nm = M_OFF;
            end else if (old == M_IDLE) begin
                if (gtx && !busy) nm = M_REQ;
            end else if (old == M_REQ) begin
                nm = M_NEG;
            end else if (old == M_NEG) begin
                if (up) begin
                    nm = M_UP; m_retries[i] = 0;
                end else if (oerr || sil) begin
                    if (m_retries[i] + 1 < MR) begin
                        nm = M_HOLD;
                        m_hold_len[i]  = BB * (1 << m_retries[i]);
                        if (m_hold_len[i] > (1 << BW) - 1) m_hold_len[i] = (1 << BW) - 1;
                        m_hold_done[i] = 0;
                    end else begin
                        nm = M_DEAD;
                    end
                    m_retries[i]++;
                end else if (!gtx) begin
                    nm = M_IDLE;
                end
            end else if (old == M_UP) begin
                if (down || !gtx) nm = M_IDLE;
                else if (cinit)   nm = M_REQ;
            end else if (old == M_HOLD) begin
                if (cinit) nm = M_REQ;
                else begin
                    m_hold_done[i]++;
                    if (m_hold_done[i] >= m_hold_len[i]) nm = M_IDLE;
                end
            end
            m_realign[i] = m_ready[i] && rx && !m_rx_prev[i];
            m_ready[i]   = (nm == M_UP) && (m_ready[i] || (old == M_UP && rx));
            m_rx_prev[i] = rx;
            m_mode[i]    = nm;
        end
    endfunction

    task automatic compare_all();
        logic [NL-1:0]    e_start, e_ready, e_realign, e_idle, e_fail;
        logic [4*NL-1:0]  e_retry;
        logic [EW*NL-1:0] e_err;
        for (int i = 0; i < NL; i++) begin
            e_start[i]   = (m_mode[i] == M_REQ);
            e_idle[i]    = (m_mode[i] == M_OFF);
            e_fail[i]    = (m_mode[i] == M_DEAD);
            e_ready[i]   = m_ready[i];
            e_realign[i] = m_realign[i];
            e_retry[4*i +: 4]  = 4'(m_retries[i]);
            e_err[EW*i +: EW]  = EW'(m_err[i]);
        end
        check("oob_start",        32'(bus.oob_start),        32'(e_start));
        check("phy_ready",        32'(bus.phy_ready),        32'(e_ready));
        check("re_aligned",       32'(bus.re_aligned),       32'(e_realign));
        check("txelecidle_force", 32'(bus.txelecidle_force), 32'(e_idle));
        check("link_fail",        32'(bus.link_fail),        32'(e_fail));
        check("retry_cnt",        32'(bus.retry_cnt),        32'(e_retry));
        check("err_cnt",          32'(bus.err_cnt),          32'(e_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until(input int lane, input int mode, input string tag);
        int budget;
        budget = 200;
        while (m_mode[lane] != mode && budget > 0) begin
            step();
            budget--;
        end
        if (m_mode[lane] != mode) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: lane %0d phase %0d, wanted phase %0d", tag, lane, m_mode[lane], mode);
        end
    endtask

    task automatic quiet_inputs();
        bus.link_up = '0; bus.link_down = '0; bus.oob_error = '0; bus.oob_silence = '0;
        bus.cominit_req = '0; bus.set_offline = '0; bus.comreset_send = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, seen;
        rst = 1'b1;
        quiet_inputs();
        bus.gtx_ready = '0; bus.oob_busy = '0; bus.rxbyteisaligned = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();

        // Bring-up: single start pulse, link, alignment.
        bus.gtx_ready = '1;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("s1_start_pulse", 32'(bus.oob_start[0]), 1);
        step();
        check("s1_start_once", 32'(bus.oob_start[0]), 0);
        bus.link_up = 2'b01; step(); bus.link_up = '0;
        bus.rxbyteisaligned[0] = 1'b1; step();
        check("s1_phy_ready", 32'(bus.phy_ready[0]), 1);
        check("s1_lane1_not_ready", 32'(bus.phy_ready[1]), 0);

        // Alignment loss while ready.
        bus.rxbyteisaligned[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s4_ready_hold", 32'(bus.phy_ready[0]), 1);
        end
        bus.rxbyteisaligned[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            cnt += int'(bus.re_aligned[0]);
        end
        check("s4_realign_once", cnt, 1);

        // Three silences: 16- then 32-cycle backoff, then FAIL.
        bus.cominit_req[0] = 1'b1; step(); bus.cominit_req[0] = 1'b0;
        step();
        for (int k = 0; k < MR; k++) begin
            bus.oob_silence[0] = 1'b1; step(); bus.oob_silence[0] = 1'b0;
            if (k < MR - 1) begin
                cnt = 0;
                while (bus.oob_start[0] !== 1'b1 && cnt < 200) begin
                    step();
                    cnt++;
                end
                check("s2_backoff_dwell", cnt, BB * (1 << k) + 1);
                step();
            end
        end
        check("s2_link_fail", 32'(bus.link_fail[0]), 1);
        check("s2_retry_cnt", 32'(bus.retry_cnt[3:0]), 3);
        check("s2_err_cnt", 32'(bus.err_cnt[7:0]), 3);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen += int'(bus.oob_start[0]);
        end
        check("s2_no_start_in_fail", seen, 0);

        // COMRESET out of FAIL.
        bus.comreset_send[0] = 1'b1; step(); bus.comreset_send[0] = 1'b0;
        check("s3_fail_cleared", 32'(bus.link_fail[0]), 0);
        check("s3_retry_cleared", 32'(bus.retry_cnt[3:0]), 0);
        seen = int'(bus.oob_start[0]);
        for (int k = 0; k < 2; k++) begin
            step();
            seen += int'(bus.oob_start[0]);
        end
        check("s3_restart", seen, 1);
        check("s3_err_kept", 32'(bus.err_cnt[7:0]), 3);

        // link_up beats oob_error in the same cycle.
        run_until(0, M_NEG, "s6_lane0_busy");
        bus.link_up[0] = 1'b1; bus.oob_error[0] = 1'b1; step(); quiet_inputs();
        check("s6_err_unchanged", 32'(bus.err_cnt[7:0]), 3);

        // Offline during BUSY, then COMRESET beats set_offline.
        run_until(1, M_NEG, "s5_lane1_busy");
        bus.set_offline[1] = 1'b1; step(); bus.set_offline[1] = 1'b0;
        check("s5_elecidle", 32'(bus.txelecidle_force[1]), 1);
        check("s5_not_ready", 32'(bus.phy_ready[1]), 0);
        repeat (3) step();
        check("s5_stays_offline", 32'(bus.txelecidle_force[1]), 1);
        bus.set_offline[1] = 1'b1; bus.comreset_send[1] = 1'b1; step(); quiet_inputs();
        check("s5_comreset_wins", 32'(bus.txelecidle_force[1]), 0);
        step();
        check("s5_restart", 32'(bus.oob_start[1]), 1);

        // Error counter saturation on lane 1.
        for (int k = 0; k < 300; k++) begin
            run_until(1, M_NEG, "s6_loop_busy");
            bus.link_up[1] = 1'b1; step(); bus.link_up[1] = 1'b0;
            bus.link_down[1] = 1'b1; step(); bus.link_down[1] = 1'b0;
        end
        check("s6_err_saturated", 32'(bus.err_cnt[15:8]), 255);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(negedge clk);
                rst = 1'b0;
            end
            for (int i = 0; i < NL; i++) begin
                bus.gtx_ready[i]       = ($urandom_range(0, 19) != 0);
                bus.oob_busy[i]        = ($urandom_range(0, 3) == 0);
                bus.link_up[i]         = ($urandom_range(0, 15) == 0);
                bus.link_down[i]       = ($urandom_range(0, 15) == 0);
                bus.oob_error[i]       = ($urandom_range(0, 15) == 0);
                bus.oob_silence[i]     = ($urandom_range(0, 15) == 0);
                bus.cominit_req[i]     = ($urandom_range(0, 19) == 0);
                bus.rxbyteisaligned[i] = ($urandom_range(0, 3) != 0);
                bus.set_offline[i]     = ($urandom_range(0, 99) == 0);
                bus.comreset_send[i]   = ($urandom_range(0, 49) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
